vec_vsetvl_ctrl: RTL and testbench
==================================

VEC_VSETVL_CTRL -- requirements
Module: vec_vsetvl_ctrl

Interface
REQ-001 Parameter XLEN, default 32: scalar and CSR data width.
REQ-002 Parameter VLEN, default 512: vector register length in bits, a power of two.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  a configuration instruction is offered.
REQ-006 req_ready  output  1  the block can accept an instruction.
REQ-007 inst  input  XLEN  instruction word.
REQ-008 rs1_data  input  XLEN  value of rs1 (AVL).
REQ-009 rs2_data  input  XLEN  value of rs2 (vtype source for vsetvl).
REQ-010 cur_vl  input  XLEN  current vl read back from the CSR register file.
REQ-011 vec_busy  input  1  the vector pipeline has operations in flight.
REQ-012 cfg_wr_en  output  1  one-cycle write strobe to the CSR register file (csrwr_en).
REQ-013 cfg_vtype  output  XLEN  new vtype (scalar2).
REQ-014 cfg_vl  output  XLEN  new vl (scalar1).
REQ-015 resp_valid  output  1  response is available.
REQ-016 resp_ready  input  1  scalar core accepts the response.
REQ-017 rd_addr  output  5  destination register, taken from inst[11:7].
REQ-018 rd_data  output  XLEN  new vl, to be written to rd.
REQ-019 rd_we  output  1  rd write enable, asserted only when rd_addr is not 0 and illegal is low.
REQ-020 illegal  output  1  the instruction was not a vset* instruction.

Function
REQ-021 FSM states: IDLE, CALC, WAIT, COMMIT, RESP; req_ready is high only in IDLE.
REQ-022 IDLE: req_valid&req_ready at edge T captures inst, rs1_data, rs2_data and cur_vl, then moves to CALC.
REQ-023 Decode: a vset* instruction has opcode 0x57 and funct3 3'b111; any other instruction goes IDLE->RESP with illegal=1, rd_we=0 and no cfg_wr_en.
REQ-024 vsetvli (inst[31]=0): vtype = inst[30:20], zero-extended; vsetivli (inst[31:30]=11): vtype = inst[29:20], AVL = inst[19:15] zero-extended; vsetvl (inst[31:25]=1000000): vtype = rs2_data.
REQ-025 AVL for vsetvli and vsetvl:
- rs1 field not 0: AVL = rs1_data.
- rs1=0 and rd not 0: AVL = all ones.
- rs1=0 and rd=0: AVL = captured cur_vl.
REQ-026 vlmul decode: 000=1, 001=2, 010=4, 011=8, 101=1/8, 110=1/4, 111=1/2; vsew decode: 000=8, 001=16, 010=32, 011=64.
REQ-027 VLMAX = VLEN*LMUL/SEW, computed by shifts with no divider.
REQ-028 vill is set if vsew[2]=1, vlmul=100, vtype bits [XLEN-2:8] are not 0, or VLMAX<1.
- On vill: cfg_vtype = 1<<(XLEN-1) and vl = 0.
REQ-029 Otherwise cfg_vtype = {0, vtype[7:0]} and vl = min(AVL, VLMAX), as an unsigned XLEN compare.
REQ-030 CALC lasts one cycle and registers cfg_vtype, cfg_vl and rd_data.
- Next state is WAIT if vec_busy=1, else COMMIT.
REQ-031 WAIT holds until vec_busy is sampled 0, then goes to COMMIT; there is no timeout.
REQ-032 COMMIT drives cfg_wr_en=1 for exactly one cycle, then goes to RESP.
REQ-033 With vec_busy=0: CALC occupies T..T+1, cfg_wr_en is high T+1..T+2, resp_valid rises at T+2.
REQ-034 RESP holds resp_valid, rd_addr, rd_data, rd_we and illegal stable until resp_valid&resp_ready, then returns to IDLE.
REQ-035 Because req_ready=0 in RESP, a req_valid in the handshake cycle is accepted in the following IDLE cycle; peak throughput is one instruction per 4 cycles.
REQ-036 cfg_vtype and cfg_vl are held stable while cfg_wr_en is high.

Reset
REQ-037 Reset values: state=IDLE, req_ready=1, cfg_wr_en=0, resp_valid=0, rd_we=0, illegal=0, and cfg_vtype, cfg_vl, rd_data, rd_addr all 0.
REQ-038 n_rst asserted in any state aborts the transaction: no cfg_wr_en pulse and no response; the block returns to IDLE.

Verification (VLEN=512)
REQ-039 vsetvli rd=5, rs1=6, zimm=0x010 (e32 m1), rs1_data=10 -> cfg_vtype=0x10, cfg_vl=10 with cfg_wr_en at T+1, rd_data=10, rd_we=1.
REQ-040 vsetvli zimm=0x003 (e8 m8), rs1_data=100 -> vl=100; rs1=0, rd=1 -> vl=512.
REQ-041 vsetivli uimm=5, vtype=0xDF (e64 mf2, ta, ma) -> VLMAX=4, cfg_vl=4, cfg_vtype=0xDF.
REQ-042 vsetvl with rs2_data=0x20 (reserved vsew) -> cfg_vtype=0x80000000, cfg_vl=0, rd_data=0.
REQ-043 vec_busy high for 5 cycles after accept -> FSM stays in WAIT with req_ready=0; cfg_wr_en fires on the cycle after vec_busy falls.
REQ-044 Two further directed cases:
- Opcode 0x33 -> resp_valid with illegal=1, rd_we=0, no cfg_wr_en.
- n_rst pulsed during WAIT -> no cfg_wr_en, resp_valid=0, req_ready=1.

Source files
------------

// File: rtl/vec_vsetvl_ctrl.sv
// vset{i}vl{i} configuration controller: decodes the instruction, derives vtype/vl
// against VLMAX, waits for the vector pipeline to drain, then commits to the CSRs.
module vec_vsetvl_ctrl #(
  parameter int XLEN = 32,
  parameter int VLEN = 512
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] cur_vl,
  input  logic            vec_busy,
  output logic            cfg_wr_en,
  output logic [XLEN-1:0] cfg_vtype,
  output logic [XLEN-1:0] cfg_vl,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_we,
  output logic            illegal
);

  localparam int         VLEN_LOG2 = $clog2(VLEN);
  localparam logic [6:0] OP_V      = 7'h57;

  typedef enum logic [2:0] {IDLE, CALC, WAIT, COMMIT, RESP} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] inst_p0, rs1_p0, rs2_p0, cur_vl_p0;
  logic            accept;

  logic [4:0]        rd_f, rs1_f;
  logic [XLEN-1:0]   vtype_src, avl, vlmax, new_vtype, new_vl;
  logic [2:0]        vsew, vlmul;
  logic signed [7:0] lmul_log2, sew_log2, vl_log2;
  logic              vill;
  logic              unused_bits;

  function automatic logic is_vset(input logic [XLEN-1:0] w);
    return (w[6:0] == OP_V) && (w[14:12] == 3'b111) &&
           (!w[31] || (w[31:30] == 2'b11) || (w[31:25] == 7'b1000000));
  endfunction

  function automatic logic [XLEN-1:0] clamp_vl(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] lim);
    return (a < lim) ? a : lim;
  endfunction

  assign accept = req_valid && req_ready;

  // Stage p0: operands captured at the request handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      inst_p0   <= inst;
      rs1_p0    <= rs1_data;
      rs2_p0    <= rs2_data;
      cur_vl_p0 <= cur_vl;
    end
  end

  // Opcode/funct3 were already checked at accept; the MSB of vtype is not part of vill
  assign unused_bits = ^{inst_p0[14:12], inst_p0[6:0], vtype_src[XLEN-1]};

  always_comb begin
    rd_f  = inst_p0[11:7];
    rs1_f = inst_p0[19:15];

    if (!inst_p0[31])
      vtype_src = {{(XLEN-11){1'b0}}, inst_p0[30:20]};
    else if (inst_p0[30])
      vtype_src = {{(XLEN-10){1'b0}}, inst_p0[29:20]};
    else
      vtype_src = rs2_p0;

    if (inst_p0[31:30] == 2'b11)
      avl = {{(XLEN-5){1'b0}}, rs1_f};
    else if (rs1_f != 5'd0)
      avl = rs1_p0;
    else if (rd_f != 5'd0)
      avl = '1;
    else
      avl = cur_vl_p0;

    vsew  = vtype_src[5:3];
    vlmul = vtype_src[2:0];

    case (vlmul)
      3'b000:  lmul_log2 = 8'sd0;
      3'b001:  lmul_log2 = 8'sd1;
      3'b010:  lmul_log2 = 8'sd2;
      3'b011:  lmul_log2 = 8'sd3;
      3'b101:  lmul_log2 = -8'sd3;
      3'b110:  lmul_log2 = -8'sd2;
      3'b111:  lmul_log2 = -8'sd1;
      default: lmul_log2 = 8'sd0;
    endcase

    // log2(VLMAX) = log2(VLEN) + log2(LMUL) - log2(SEW); negative means VLMAX < 1
    sew_log2 = 8'sd3 + $signed({6'd0, vsew[1:0]});
    vl_log2  = $signed(8'(VLEN_LOG2)) + lmul_log2 - sew_log2;
    vlmax    = (vl_log2 < 8'sd0) ? '0 : ({{(XLEN-1){1'b0}}, 1'b1} << vl_log2[6:0]);

    vill      = vsew[2] || (vlmul == 3'b100) || (|vtype_src[XLEN-2:8]) || (vlmax == '0);
    new_vtype = vill ? {1'b1, {(XLEN-1){1'b0}}} : {{(XLEN-8){1'b0}}, vtype_src[7:0]};
    new_vl    = vill ? '0 : clamp_vl(avl, vlmax);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    cfg_wr_en  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = is_vset(inst) ? CALC : RESP;
      end
      CALC:   state_nxt = vec_busy ? WAIT : COMMIT;
      WAIT:   if (!vec_busy) state_nxt = COMMIT;
      COMMIT: begin
        cfg_wr_en = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: result registers, held through COMMIT and RESP
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cfg_vtype <= '0;
      cfg_vl    <= '0;
      rd_data   <= '0;
      rd_addr   <= '0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (accept) begin
        rd_addr <= inst[11:7];
        illegal <= !is_vset(inst);
        rd_we   <= 1'b0;
        rd_data <= '0;
      end
      if (state == CALC) begin
        cfg_vtype <= new_vtype;
        cfg_vl    <= new_vl;
        rd_data   <= new_vl;
        rd_we     <= (rd_f != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_vec_vsetvl_ctrl.sv
// Scoreboard bench for vec_vsetvl_ctrl: directed cases plus randomized vset* traffic
// checked against an arithmetic reference model.
module tb_vec_vsetvl_ctrl;
  localparam int XLEN = 32;
  localparam int VLEN = 512;

  logic            clk, n_rst, req_valid, req_ready, vec_busy, cfg_wr_en;
  logic            resp_valid, resp_ready, rd_we, illegal;
  logic [XLEN-1:0] inst, rs1_data, rs2_data, cur_vl, cfg_vtype, cfg_vl, rd_data;
  logic [4:0]      rd_addr;

  int   checks = 0;
  int   errors = 0;
  logic busy_rand = 1'b0, busy_force = 1'b0, ready_rand = 1'b0;

  typedef struct packed {logic [31:0] vt; logic [31:0] vl;} cfg_t;
  typedef struct packed {logic ill; logic [4:0] rd; logic [31:0] data; logic we;} resp_t;
  cfg_t  cfg_q[$];
  resp_t resp_q[$];

  vec_vsetvl_ctrl #(.XLEN(XLEN), .VLEN(VLEN)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data), .cur_vl(cur_vl),
    .vec_busy(vec_busy), .cfg_wr_en(cfg_wr_en), .cfg_vtype(cfg_vtype), .cfg_vl(cfg_vl),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_we(rd_we), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: VLMAX = VLEN*LMUL/SEW by plain integer arithmetic
  function automatic void model(input logic [31:0] ins, r1, r2, cv,
                                output logic ill, output logic [4:0] rd,
                                output logic [31:0] vt, output logic [31:0] vl,
                                output logic we);
    logic [31:0] src, avl, vlmax;
    logic [4:0]  rs1f;
    int          num, den, sew;
    logic        bad;
    rd   = ins[11:7];
    rs1f = ins[19:15];
    ill  = !((ins[6:0] == 7'h57) && (ins[14:12] == 3'b111) &&
             (ins[31] == 1'b0 || ins[31:30] == 2'b11 || ins[31:25] == 7'b1000000));
    vt = 0; vl = 0; we = 0;
    if (ill) return;
    if (ins[31] == 1'b0)       src = {21'd0, ins[30:20]};
    else if (ins[30] == 1'b1)  src = {22'd0, ins[29:20]};
    else                       src = r2;
    if (ins[31:30] == 2'b11)   avl = {27'd0, rs1f};
    else if (rs1f != 0)        avl = r1;
    else if (rd != 0)          avl = 32'hFFFF_FFFF;
    else                       avl = cv;
    bad = (src[5:3] > 3) || (src[2:0] == 3'd4) || (src[30:8] != 0);
    vlmax = 0;
    if (!bad) begin
      sew = 8 << src[5:3];
      if (src[2] == 1'b0) begin num = 1 << src[2:0]; den = 1; end
      else begin num = 1; den = 1 << (4 - src[1:0]); end
      vlmax = 32'((VLEN * num) / (den * sew));
      bad = (vlmax == 0);
    end
    vt = bad ? 32'h8000_0000 : {24'd0, src[7:0]};
    vl = bad ? 32'd0 : ((avl < vlmax) ? avl : vlmax);
    we = (rd != 0);
  endfunction

  task automatic push_exp(input logic ill, input logic [4:0] rd, input logic [31:0] vt,
                          input logic [31:0] vl, input logic we);
    cfg_t  c;
    resp_t r;
    c.vt = vt; c.vl = vl;
    r.ill = ill; r.rd = rd; r.data = vl; r.we = we;
    if (!ill) cfg_q.push_back(c);
    resp_q.push_back(r);
  endtask

  task automatic issue(input logic [31:0] ins, r1, r2, cv);
    int n = 0;
    @(posedge clk); #1;
    inst = ins; rs1_data = r1; rs2_data = r2; cur_vl = cv; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((cfg_q.size() != 0 || resp_q.size() != 0 || !req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_cfg_q", 64'(cfg_q.size()), 64'd0);
    chk("drain_resp_q", 64'(resp_q.size()), 64'd0);
  endtask

  // Handshake inputs change only just after the rising edge
  initial begin
    vec_busy   = 1'b0;
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      vec_busy   = busy_rand  ? ($urandom_range(0, 2) == 0) : busy_force;
      resp_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor
  initial begin
    cfg_t  c;
    resp_t r;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (cfg_wr_en) begin
          if (cfg_q.size() == 0) chk("cfg_unexpected_pending", 64'(cfg_q.size()), 64'd1);
          else begin
            c = cfg_q.pop_front();
            chk("cfg_vtype", 64'(cfg_vtype), 64'(c.vt));
            chk("cfg_vl", 64'(cfg_vl), 64'(c.vl));
          end
        end
        if (resp_valid && resp_ready) begin
          if (resp_q.size() == 0) chk("resp_unexpected_pending", 64'(resp_q.size()), 64'd1);
          else begin
            r = resp_q.pop_front();
            chk("illegal", 64'(illegal), 64'(r.ill));
            chk("rd_addr", 64'(rd_addr), 64'(r.rd));
            chk("rd_we", 64'(rd_we), 64'(r.we));
            if (!r.ill) chk("rd_data", 64'(rd_data), 64'(r.data));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] w, vt, r1, r2, cv, evt, evl;
    logic [4:0]  rd, rs1;
    logic        eill, ewe;
    int          kind;

    n_rst = 1'b0; req_valid = 1'b0;
    inst = '0; rs1_data = '0; rs2_data = '0; cur_vl = '0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_cfg_wr_en", 64'(cfg_wr_en), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rd_we", 64'(rd_we), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_cfg_vtype", 64'(cfg_vtype), 64'd0);
    chk("rst_cfg_vl", 64'(cfg_vl), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);

    // vsetvli e32 m1 with latency check
    push_exp(1'b0, 5'd5, 32'h10, 32'd10, 1'b1);
    issue({1'b0, 11'h010, 5'd6, 3'b111, 5'd5, 7'h57}, 32'd10, 32'd0, 32'd0);
    @(negedge clk); chk("lat_T0_wr_en", 64'(cfg_wr_en), 64'd0);
    chk("lat_T0_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk); chk("lat_T1_wr_en", 64'(cfg_wr_en), 64'd1);
    @(negedge clk); chk("lat_T2_resp_valid", 64'(resp_valid), 64'd1);
    chk("lat_T2_wr_en", 64'(cfg_wr_en), 64'd0);
    wait_done();

    // e8 m8: AVL from rs1, then AVL = all ones
    push_exp(1'b0, 5'd3, 32'h03, 32'd100, 1'b1);
    issue({1'b0, 11'h003, 5'd7, 3'b111, 5'd3, 7'h57}, 32'd100, 32'd0, 32'd0);
    push_exp(1'b0, 5'd1, 32'h03, 32'd512, 1'b1);
    issue({1'b0, 11'h003, 5'd0, 3'b111, 5'd1, 7'h57}, 32'd100, 32'd0, 32'd0);
    // vsetivli e64 mf2 ta ma, uimm 5 -> VLMAX 4
    push_exp(1'b0, 5'd2, 32'hDF, 32'd4, 1'b1);
    issue({2'b11, 10'h0DF, 5'd5, 3'b111, 5'd2, 7'h57}, 32'd0, 32'd0, 32'd0);
    // vsetvl with reserved vsew
    push_exp(1'b0, 5'd7, 32'h8000_0000, 32'd0, 1'b1);
    issue({7'b1000000, 5'd3, 5'd4, 3'b111, 5'd7, 7'h57}, 32'd50, 32'h20, 32'd0);
    // OP (0x33) is not a vset*
    push_exp(1'b1, 5'd10, 32'd0, 32'd0, 1'b0);
    issue(32'h00C5_8533, 32'd1, 32'd2, 32'd3);
    wait_done();

    // vec_busy held for 5 cycles after accept
    busy_force = 1'b1;
    repeat (2) @(posedge clk);
    push_exp(1'b0, 5'd5, 32'h10, 32'd7, 1'b1);
    issue({1'b0, 11'h010, 5'd6, 3'b111, 5'd5, 7'h57}, 32'd7, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_req_ready", 64'(req_ready), 64'd0);
      chk("busy_wr_en", 64'(cfg_wr_en), 64'd0);
    end
    busy_force = 1'b0;
    @(negedge clk); chk("busy_fall_wr_en0", 64'(cfg_wr_en), 64'd0);
    @(negedge clk); chk("busy_fall_wr_en1", 64'(cfg_wr_en), 64'd1);
    wait_done();

    // Reset while waiting on vec_busy aborts the transaction
    busy_force = 1'b1;
    repeat (2) @(posedge clk);
    issue({1'b0, 11'h010, 5'd6, 3'b111, 5'd5, 7'h57}, 32'd9, 32'd0, 32'd0);
    @(negedge clk); @(negedge clk);
    chk("wait_req_ready", 64'(req_ready), 64'd0);
    n_rst = 1'b0;
    #2;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_wr_en", 64'(cfg_wr_en), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    busy_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_wr_en", 64'(cfg_wr_en), 64'd0);
      chk("post_abort_resp_valid", 64'(resp_valid), 64'd0);
    end

    // Randomized traffic with random back-pressure and busy
    busy_rand = 1'b1; ready_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      vt   = 32'd0;
      vt[7:6] = 2'($urandom_range(0, 3));
      vt[5:3] = 3'($urandom_range(0, 4));
      vt[2:0] = 3'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 600)) : $urandom;
      cv = 32'($urandom_range(0, 512));
      r2 = $urandom;
      w  = $urandom;
      if (kind == 0) begin
        if ($urandom_range(0, 1) == 0) w[6:0] = 7'h33;
        else begin w[6:0] = 7'h57; w[14:12] = 3'($urandom_range(0, 6)); end
      end else if (kind == 1) begin
        w[31:30] = 2'b10; w[25] = 1'b1; w[14:12] = 3'b111; w[6:0] = 7'h57;
      end else if (kind <= 4) begin
        if ($urandom_range(0, 9) == 0) vt[10:8] = 3'($urandom_range(1, 7));
        w = {1'b0, vt[10:0], rs1, 3'b111, rd, 7'h57};
      end else if (kind <= 7) begin
        if ($urandom_range(0, 9) == 0) vt[9:8] = 2'($urandom_range(1, 3));
        w = {2'b11, vt[9:0], 5'($urandom_range(0, 31)), 3'b111, rd, 7'h57};
      end else begin
        if ($urandom_range(0, 9) == 0) vt[30:8] = 23'($urandom_range(1, 32'h7FFFFF));
        r2 = vt;
        w  = {7'b1000000, 5'($urandom_range(0, 31)), rs1, 3'b111, rd, 7'h57};
      end
      model(w, r1, r2, cv, eill, rd, evt, evl, ewe);
      push_exp(eill, rd, evt, evl, ewe);
      issue(w, r1, r2, cv);
    end
    busy_rand = 1'b0; ready_rand = 1'b0;
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
